// File: rtl/philosophy_v_pkg.sv
// ---------------------------------------------------------------------------
// philosophy_v_pkg
// Shared definitions for the PhilosophyV RV32I execute core:
//   - major opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI)
//   - funct3 / funct7 field constants
//   - alu_op_t, the operation selector handed from decode to the ALU
// No ports; imported by philosophy_v_alu and philosophy_v_core.
// ---------------------------------------------------------------------------
package philosophy_v_pkg;

    localparam int XLEN = 32;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 (instr[14:12])
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 (instr[31:25])
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ADD,
        SUB,
        SLL,
        SLT,
        SLTU,
        XOR,
        SRL,
        SRA,
        OR,
        AND,
        PASS_B,
        MUL,
        MULH,
        MULHSU,
        MULHU
    } alu_op_t;

endpackage

// File: rtl/philosophy_v_alu.sv
// ---------------------------------------------------------------------------
// philosophy_v_alu
// Purely combinational integer ALU for the PhilosophyV core.
// Ports:
//   alu_op  in   alu_op_t  operation selected by decode
//   op1     in   XLEN      first operand (rs1 value)
//   op2     in   XLEN      second operand (rs2 value or immediate)
//   result  out  XLEN      operation result
// Configuration macro: PHILV_MUL_EN adds MUL/MULH/MULHSU/MULHU; when it is
// undefined no multiplier exists and those selectors return zero.
// ---------------------------------------------------------------------------
module philosophy_v_alu
    import philosophy_v_pkg::*;
(
    input  alu_op_t           alu_op,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    output logic [XLEN-1:0]   result
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

`ifdef PHILV_MUL_EN
    // A single 64x64 multiplier serves all four variants: each operand is
    // sign- or zero-extended to 64 bits, and the low 64 bits of the product
    // are then correct for every signedness combination.
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] product;
    logic              sign_a;
    logic              sign_b;

    always_comb begin
        sign_a  = op1[XLEN-1] & ((alu_op == MULH) || (alu_op == MULHSU));
        sign_b  = op2[XLEN-1] & (alu_op == MULH);
        mul_a   = {{XLEN{sign_a}}, op1};
        mul_b   = {{XLEN{sign_b}}, op2};
        product = mul_a * mul_b;
    end
`endif

    always_comb begin
        result = '0;
        case (alu_op)
            ADD:    result = op1 + op2;
            SUB:    result = op1 - op2;
            SLL:    result = op1 << shamt;
            SLT:    result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            SLTU:   result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            XOR:    result = op1 ^ op2;
            SRL:    result = op1 >> shamt;
            SRA:    result = $unsigned($signed(op1) >>> shamt);
            OR:     result = op1 | op2;
            AND:    result = op1 & op2;
            PASS_B: result = op2;
`ifdef PHILV_MUL_EN
            MUL:    result = product[XLEN-1:0];
            MULH,
            MULHSU,
            MULHU:  result = product[2*XLEN-1:XLEN];
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/philosophy_v_core.sv
// ---------------------------------------------------------------------------
// philosophy_v_core
// Single-issue RV32I integer execute core: decodes one instruction word,
// builds the second operand, and produces the result combinationally.
// A clocked status section counts retired legal instructions and keeps a
// sticky illegal-instruction flag.
// Ports:
//   clk           in   1   system clock (rising edge)
//   rst           in   1   synchronous active-high reset
//   instr         in   32  RV32 instruction word
//   a             in   N   rs1 operand value
//   b             in   N   rs2 operand value (unused by immediate forms)
//   c             out  N   result, combinational, zero when illegal
//   illegal       out  1   combinational unsupported-encoding indication
//   illegal_seen  out  1   registered sticky illegal flag
//   retired       out  32  registered count of legal instructions
// Configuration macro: PHILV_MUL_EN makes the OP funct7=0000001 MUL family
// (funct3 000..011) legal; otherwise the whole funct7=0000001 space is illegal.
// ---------------------------------------------------------------------------
module philosophy_v_core
    import philosophy_v_pkg::*;
#(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   instr,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic [N-1:0]  c,
    output logic          illegal,
    output logic          illegal_seen,
    output logic [31:0]   retired
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    alu_op_t     alu_op;
    logic [N-1:0] op2;
    logic [N-1:0] alu_result;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    // Register specifiers are resolved by the surrounding datapath.
    logic unused_fields;
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    // Immediate shifts reuse imm_i: its low five bits are exactly the
    // shift amount, and the ALU only looks at those bits for shifts.
    always_comb begin
        alu_op  = ADD;
        op2     = b;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                op2 = b;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  alu_op = ADD;
                        F3_SLL:  alu_op = SLL;
                        F3_SLT:  alu_op = SLT;
                        F3_SLTU: alu_op = SLTU;
                        F3_XOR:  alu_op = XOR;
                        F3_SR:   alu_op = SRL;
                        F3_OR:   alu_op = OR;
                        F3_AND:  alu_op = AND;
                        default: illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    alu_op = SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    alu_op = SRA;
`ifdef PHILV_MUL_EN
                end else if (funct7 == F7_MULDIV && !funct3[2]) begin
                    case (funct3[1:0])
                        2'b00:   alu_op = MUL;
                        2'b01:   alu_op = MULH;
                        2'b10:   alu_op = MULHSU;
                        default: alu_op = MULHU;
                    endcase
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                op2 = imm_i;
                case (funct3)
                    F3_ADD:  alu_op = ADD;
                    F3_SLT:  alu_op = SLT;
                    F3_SLTU: alu_op = SLTU;
                    F3_XOR:  alu_op = XOR;
                    F3_OR:   alu_op = OR;
                    F3_AND:  alu_op = AND;
                    F3_SLL: begin
                        if (funct7 == F7_BASE) alu_op = SLL;
                        else                   illegal = 1'b1;
                    end
                    F3_SR: begin
                        if (funct7 == F7_BASE)     alu_op = SRL;
                        else if (funct7 == F7_ALT) alu_op = SRA;
                        else                       illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                op2    = imm_u;
                alu_op = PASS_B;
            end
            default: illegal = 1'b1;
        endcase
    end

    philosophy_v_alu u_alu (
        .alu_op (alu_op),
        .op1    (a),
        .op2    (op2),
        .result (alu_result)
    );

    assign c = illegal ? '0 : alu_result;

    // Status: reset dominates; otherwise count legal instructions (wrapping
    // naturally at 2^32) and latch any illegal one until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired      <= '0;
            illegal_seen <= 1'b0;
        end else begin
            if (!illegal) retired <= retired + 32'd1;
            if (illegal)  illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_philosophy_v_core.sv
// ---------------------------------------------------------------------------
// tb_philosophy_v_core
// Self-checking bench for philosophy_v_core: directed vectors from the test
// plan followed by randomized instructions compared against a behavioural
// reference model of RV32I (plus the MUL family when PHILV_MUL_EN is set).
// ---------------------------------------------------------------------------
module tb_philosophy_v_core;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        illegal;
    logic        illegal_seen;
    logic [31:0] retired;

    int numChecks;
    int numMiscompares;

    // Reference status state, updated per rising edge from the model's view
    // of legality rather than from the DUT.
    logic [31:0] expRetired;
    logic        expSeen;

`ifdef PHILV_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    philosophy_v_core #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .a            (a),
        .b            (b),
        .c            (c),
        .illegal      (illegal),
        .illegal_seen (illegal_seen),
        .retired      (retired)
    );

    // 20 ns period clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Architectural reference: computes the result straight from the
    // instruction semantics using wide integer arithmetic.
    function automatic void refModel(input logic [31:0] ins, input logic [31:0] x,
                                     input logic [31:0] y, output logic [31:0] res,
                                     output logic ill);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] src2;
        logic [4:0]  sh;
        logic [63:0] prod;
        longint      sx;
        longint      sy;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        res  = 32'h0;
        ill  = 1'b0;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        if (opc == 7'h37) begin
            res = {ins[31:12], 12'h000};
            return;
        end
        if (opc == 7'h13) begin
            src2 = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
            if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        end else if (opc == 7'h33) begin
            src2 = y;
            if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
            if (f7 == 7'h01) begin
                if (!MUL_EN || f3 > 3'd3) begin
                    ill = 1'b1;
                end else begin
                    case (f3)
                        3'd0: prod = 64'(x) * 64'(y);
                        3'd1: prod = 64'(sx * sy);
                        3'd2: prod = 64'(sx * longint'({32'h0, y}));
                        default: prod = {32'h0, x} * {32'h0, y};
                    endcase
                    res = (f3 == 3'd0) ? prod[31:0] : prod[63:32];
                    return;
                end
            end
            if (f7 != 7'h00 && f7 != 7'h20 && f7 != 7'h01) ill = 1'b1;
        end else begin
            ill = 1'b1;
        end
        if (ill) return;
        sh = src2[4:0];
        case (f3)
            3'd0: res = (opc == 7'h33 && f7 == 7'h20) ? x - src2 : x + src2;
            3'd1: res = x << sh;
            3'd2: res = (sx < longint'($signed(src2))) ? 32'd1 : 32'd0;
            3'd3: res = ({32'h0, x} < {32'h0, src2}) ? 32'd1 : 32'd0;
            3'd4: res = x ^ src2;
            3'd5: begin
                res = x >> sh;
                if (f7 == 7'h20 && x[31]) res = res | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: res = x | src2;
            default: res = x & src2;
        endcase
    endfunction

    // Drive one instruction (at a falling edge), check the combinational
    // outputs 8 ns later, and advance the status model for the coming edge.
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] x,
                                 input logic [31:0] y, input logic r);
        logic [31:0] expC;
        logic        expIll;
        instr = ins;
        a     = x;
        b     = y;
        rst   = r;
        #8;
        refModel(ins, x, y, expC, expIll);
        checkOutput("c", c, expC);
        checkOutput("illegal", {31'h0, illegal}, {31'h0, expIll});
        if (r) begin
            expRetired = 32'h0;
            expSeen    = 1'b0;
        end else begin
            if (!expIll) expRetired = expRetired + 32'd1;
            if (expIll)  expSeen    = 1'b1;
        end
    endtask

    // Wait past the rising edge to the falling edge and check status regs.
    task automatic stepEdge();
        @(negedge clk);
        checkOutput("retired", retired, expRetired);
        checkOutput("illegal_seen", {31'h0, illegal_seen}, {31'h0, expSeen});
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [6:0]  f7;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 6))
            0, 1, 2: w = {f7, w[24:7], 7'h33};
            3, 4:    w = {f7, w[24:7], 7'h13};
            5:       w = {w[31:7], 7'h37};
            default: w = w;
        endcase
        return w;
    endfunction

    initial begin
        numChecks      = 0;
        numMiscompares = 0;
        expRetired     = 32'h0;
        expSeen        = 1'b0;
        rst   = 1'b1;
        instr = 32'h0;
        a     = 32'h0;
        b     = 32'h0;

        // Reset for one cycle
        applyStimulus(32'h002081B3, 32'd5, 32'd7, 1'b1);
        stepEdge();
        checkOutput("tp_reset_retired", retired, 32'd0);
        checkOutput("tp_reset_seen", {31'h0, illegal_seen}, 32'd0);

        // Three legal instructions from the test plan
        applyStimulus(32'h002081B3, 32'd5, 32'd7, 1'b0);
        checkOutput("tp_add", c, 32'd12);
        stepEdge();
        applyStimulus(32'h402081B3, 32'd5, 32'd7, 1'b0);
        checkOutput("tp_sub", c, 32'hFFFF_FFFE);
        stepEdge();
        applyStimulus(32'h4020D1B3, 32'h8000_0000, 32'h24, 1'b0);
        checkOutput("tp_sra", c, 32'hF800_0000);
        stepEdge();
        checkOutput("tp_retired3", retired, 32'd3);

        applyStimulus(32'h0020B1B3, 32'd1, 32'hFFFF_FFFF, 1'b0);
        checkOutput("tp_sltu", c, 32'd1);
        stepEdge();
        applyStimulus(32'hFFF08193, 32'd0, 32'd0, 1'b0);
        checkOutput("tp_addi_m1", c, 32'hFFFF_FFFF);
        stepEdge();
        applyStimulus(32'h123451B7, 32'hDEAD_BEEF, 32'h1, 1'b0);
        checkOutput("tp_lui", c, 32'h1234_5000);
        stepEdge();

        // Illegal word and sticky flag
        applyStimulus(32'h0000_0000, 32'h1234, 32'h5678, 1'b0);
        checkOutput("tp_illegal_c", c, 32'd0);
        checkOutput("tp_illegal_flag", {31'h0, illegal}, 32'd1);
        stepEdge();
        checkOutput("tp_seen_set", {31'h0, illegal_seen}, 32'd1);
        applyStimulus(32'h002081B3, 32'd1, 32'd1, 1'b0);
        stepEdge();
        checkOutput("tp_seen_hold", {31'h0, illegal_seen}, 32'd1);

        // Multiply family
        applyStimulus(32'h022081B3, 32'hFFFF_FFFF, 32'd2, 1'b0);
`ifdef PHILV_MUL_EN
        checkOutput("tp_mul", c, 32'hFFFF_FFFE);
        checkOutput("tp_mul_legal", {31'h0, illegal}, 32'd0);
`else
        checkOutput("tp_mul", c, 32'd0);
        checkOutput("tp_mul_illegal", {31'h0, illegal}, 32'd1);
`endif
        stepEdge();
        applyStimulus(32'h022091B3, 32'hFFFF_FFFF, 32'd2, 1'b0);
`ifdef PHILV_MUL_EN
        checkOutput("tp_mulh", c, 32'hFFFF_FFFF);
`else
        checkOutput("tp_mulh", c, 32'd0);
`endif
        stepEdge();

        // Reset together with a legal instruction wins
        applyStimulus(32'h002081B3, 32'd3, 32'd4, 1'b1);
        stepEdge();
        checkOutput("tp_rst_over_inc", retired, 32'd0);
        checkOutput("tp_rst_clears_seen", {31'h0, illegal_seen}, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            applyStimulus(randInstr(), randOperand(), randOperand(),
                          ($urandom_range(0, 31) == 0));
            stepEdge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numMiscompares);
        $finish;
    end

endmodule
